// File: rtl/fft_stage_pair_sequencer_if.sv
// ----------------------------------------------------------------------------
// fft_stage_pair_sequencer_if
//   Stream bundle for fft_stage_pair_sequencer: the sample input stream
//   (in_valid/in_ready/in_data) and the butterfly-pair output stream
//   (out_valid/out_ready/out_data_a/b, out_idx_a/b, out_last).
//
//   Modports:
//     slave  - the sequencer side: consumes samples, produces pairs
//     master - the surrounding environment: produces samples, consumes pairs
//
//   Parameters:
//     WIDTH  - sample width in bits
//     ADDR_W - pair index width ($clog2 of the frame length)
// ----------------------------------------------------------------------------
interface fft_stage_pair_sequencer_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 5
);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;

  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data_a;
  logic [WIDTH-1:0]  out_data_b;
  logic [ADDR_W-1:0] out_idx_a;
  logic [ADDR_W-1:0] out_idx_b;
  logic              out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data_a, out_data_b,
           out_idx_a, out_idx_b, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data_a, out_data_b,
           out_idx_a, out_idx_b, out_last
  );

endinterface

// File: rtl/fft_stage_pair_sequencer.sv
// ----------------------------------------------------------------------------
// fft_stage_pair_sequencer
//   Captures a frame of SAMPLES samples into a register buffer, then streams
//   the radix-2 butterfly pairs (l+j, l+j+2^stage) of a run-time selected
//   stage, one pair per output handshake. Pairs come out with groups
//   ascending and j ascending inside each group.
//
//   Ports:
//     clk    - clock, everything on the rising edge
//     rst_n  - synchronous active-low reset (abandons any frame in flight)
//     start  - begin a frame; only looked at in IDLE
//     stage  - stage select, latched when start is accepted
//     busy   - high whenever the sequencer is not IDLE
//     err    - one-cycle pulse after a start with an out-of-range stage
//     bus    - fft_stage_pair_sequencer_if.slave:
//                in_valid/in_ready/in_data         sample input stream
//                out_valid/out_ready               pair output handshake
//                out_idx_a/out_idx_b               lower/upper pair index
//                out_data_a/out_data_b             buffer[idx_a]/buffer[idx_b]
//                out_last                          final pair of the frame
//
//   Build option:
//     FFT_BITREV_LOAD_EN - when defined, sample n of the frame is stored at
//                          buffer[bitrev(n)] (decimation-in-time order);
//                          otherwise samples are stored in natural order.
// ----------------------------------------------------------------------------
module fft_stage_pair_sequencer #(
  parameter int SAMPLES = 32,
  parameter int WIDTH   = 8,
  parameter int ADDR_W  = $clog2(SAMPLES),
  parameter int STAGE_W = $clog2($clog2(SAMPLES))
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [STAGE_W-1:0]        stage,
  output logic                      busy,
  output logic                      err,
  fft_stage_pair_sequencer_if.slave bus
);

  localparam int unsigned LOG2N = $clog2(SAMPLES);
  localparam int unsigned PAIRS = SAMPLES / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [ADDR_W-1:0]  wr_cnt;
  logic [ADDR_W-1:0]  wr_addr;
  logic [ADDR_W-1:0]  p;
  logic [STAGE_W-1:0] stage_q;
  logic               err_q;
  logic [WIDTH-1:0]   buffer [SAMPLES];

  logic               stage_ok;
  logic               start_acc;
  logic               start_rej;
  logic               in_fire;
  logic               out_fire;
  logic               load_done;
  logic               pair_last;

  logic [ADDR_W-1:0]  half;
  logic [ADDR_W-1:0]  j;
  logic [ADDR_W-1:0]  g;
  logic [ADDR_W-1:0]  idx_a;
  logic [ADDR_W-1:0]  idx_b;

`ifdef FFT_BITREV_LOAD_EN
  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < ADDR_W; i++) begin
      r[i] = v[ADDR_W-1-i];
    end
    return r;
  endfunction
`endif

  // --------------------------------------------------------------------------
  // Decode of handshakes, start qualification and pair index arithmetic
  // --------------------------------------------------------------------------
  always_comb begin
    stage_ok  = (32'(stage) < LOG2N);
    start_acc = (state == IDLE) && start && stage_ok;
    start_rej = (state == IDLE) && start && !stage_ok;

    in_fire   = bus.in_valid && bus.in_ready;
    out_fire  = bus.out_valid && bus.out_ready;
    load_done = in_fire && (wr_cnt == ADDR_W'(SAMPLES - 1));
    pair_last = (p == ADDR_W'(PAIRS - 1));

`ifdef FFT_BITREV_LOAD_EN
    wr_addr = bitrev(wr_cnt);
`else
    wr_addr = wr_cnt;
`endif

    // p counts pairs; its low stage_q bits are j, the rest select the group.
    // Each group spans 2*half indices, so the group base is g << (stage_q+1).
    // The shift amount is widened to int so stage_q+1 cannot wrap.
    half  = ADDR_W'(1) << stage_q;
    j     = p & (half - ADDR_W'(1));
    g     = p >> stage_q;
    idx_a = (g << (int'(stage_q) + 1)) + j;
    idx_b = idx_a + half;
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and stream outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    bus.in_ready   = 1'b0;
    bus.out_valid  = 1'b0;
    bus.out_last   = 1'b0;
    bus.out_idx_a  = '0;
    bus.out_idx_b  = '0;
    bus.out_data_a = '0;
    bus.out_data_b = '0;
    busy           = (state != IDLE);
    err            = err_q;

    unique case (state)
      IDLE: begin
        if (start_acc) begin
          state_nxt = LOAD;
        end
      end

      LOAD: begin
        bus.in_ready = 1'b1;
        if (load_done) begin
          state_nxt = EMIT;
        end
      end

      EMIT: begin
        // Pair outputs are forced to zero outside EMIT so the idle bus
        // shows index 0/0 rather than the (0,1) pair of stage 0.
        bus.out_valid  = 1'b1;
        bus.out_last   = pair_last;
        bus.out_idx_a  = idx_a;
        bus.out_idx_b  = idx_b;
        bus.out_data_a = buffer[idx_a];
        bus.out_data_b = buffer[idx_b];
        if (out_fire && pair_last) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: counters, latched stage, error pulse and sample buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      p       <= '0;
      stage_q <= '0;
      err_q   <= 1'b0;
      buffer  <= '{default: '0};
    end else begin
      err_q <= start_rej;

      if (start_acc) begin
        stage_q <= stage;
        wr_cnt  <= '0;
        p       <= '0;
      end

      // wr_cnt wraps to zero on the final sample since SAMPLES is 2^ADDR_W.
      if (in_fire) begin
        buffer[wr_addr] <= bus.in_data;
        wr_cnt          <= wr_cnt + ADDR_W'(1);
      end

      if (out_fire) begin
        p <= pair_last ? '0 : p + ADDR_W'(1);
      end
    end
  end

endmodule
